uart_rx: RTL

UART receiver for the 50 MHz design: recovers 8N1 frames from a serial line and presents each byte as a one-cycle `valid` pulse with the byte on `data`. It sits directly downstream of the team's UART transmitter, on its `tx` line in loopback benches or on the board pin in hardware. It uses the same `baud_sel` encoding and bit-period table as the transmitter, so both ends agree on timing by construction.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 14 +
 rtl/sync_2ff.sv | 22 ++
 rtl/uart_rx.sv | 113 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM states and the baud_sel
// bit-period table used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int CNT_W       = 13;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   // Bit period in 50 MHz clock cycles; codes 4..7 all select 115200 baud.
   function automatic logic [CNT_W-1:0] BIT_PERIOD(input logic [2:0] sel);
      case (sel)
         3'd0:    BIT_PERIOD = 13'd5208;
         3'd1:    BIT_PERIOD = 13'd2604;
         3'd2:    BIT_PERIOD = 13'd1302;
         3'd3:    BIT_PERIOD = 13'd868;
         default: BIT_PERIOD = 13'd434;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus: the receiver drives it through the master modport,
// the consumer watches it through the slave modport.
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] data;
   logic                   valid;
   logic                   frame_err;
   logic                   busy;

   modport master (output data, valid, frame_err, busy);
   modport slave  (input  data, valid, frame_err, busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both stages reset to 1 so
// an idle-high serial line shows no false edge when reset is released.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge-aligned counter,
// one-cycle valid / frame_err pulses, break lockout after a framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] baud_sel,
   input  logic       rx,
   uart_rx_if.master  bus
);

   if (CLK_HZ != 50_000_000) begin : g_clk_check
      $error("uart_rx bit-period table is only valid for a 50 MHz clock");
   end

   logic                   rx_s;
   rx_state_t              state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       bit_len;
   logic [2:0]             bit_idx;
   logic [UART_DATA_W-1:0] shift;
   logic [UART_DATA_W-1:0] data_q;
   logic                   valid_q;
   logic                   ferr_q;
   logic                   armed;
   logic                   sample;
   logic                   done_ok;
   logic                   done_err;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      done_ok   = 1'b0;
      done_err  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_s && armed) state_nxt = START;
         end
         START: begin
            if (cnt == (bit_len >> 1) - 13'd1) begin
               sample    = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == bit_len - 13'd1) begin
               sample = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == bit_len - 13'd1) begin
               sample    = 1'b1;
               state_nxt = IDLE;
               done_ok   = rx_s;
               done_err  = !rx_s;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_len <= BIT_PERIOD(3'd4);
         bit_idx <= '0;
         armed   <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= done_ok;
         ferr_q  <= done_err;
         if (done_ok) data_q <= shift;
         // The rate is re-latched every idle cycle, so it freezes at the start edge.
         if (state == IDLE) begin
            cnt     <= '0;
            bit_idx <= '0;
            bit_len <= BIT_PERIOD(baud_sel);
         end else if (sample) begin
            cnt <= '0;
            if (state == DATA) bit_idx <= bit_idx + 3'd1;
         end else begin
            cnt <= cnt + 13'd1;
         end
         // A low stop bit disarms start detection until the line is seen high.
         if (rx_s) armed <= 1'b1;
         else if (done_err) armed <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && sample) shift <= {rx_s, shift[UART_DATA_W-1:1]};
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state != IDLE);

endmodule
